// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// RV32I opcode constants and the FSM state encoding.
package pipeline_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        PIPELINE_CTRL_RUN      = 2'd0,
        PIPELINE_CTRL_FLUSH    = 2'd1,
        PIPELINE_CTRL_MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_rs_use_decode.sv
// Source-register use decode: which of rs1/rs2 an opcode reads.
// Ports: opcode (in 7), use1 / use2 (out 1).
module rs_use_decode
    import pipeline_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       use1,
    output logic       use2
);

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                use1 = 1'b1;
            end
            default: begin
                use1 = 1'b0;
                use2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer (RUN / FLUSH / MEM_WAIT), Mealy outputs.
// Inputs: clk, rst (sync, active-high), ID operands, EX rd/load/redirect,
//   memory handshake. Outputs: per-register stall/flush/bubble, state.
// Optional macro PIPELINE_CTRL_PERF_EN adds perf_stall_cycles and
//   perf_flush_cycles (PERF_WIDTH wide, saturating).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            id_opcode,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req_valid,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_stall,
    output logic [1:0]            state
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles,
    output logic [PERF_WIDTH-1:0] perf_flush_cycles
`endif
);

    localparam int CW = $clog2(FLUSH_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic use1, use2;
    logic lu;
    logic miss;

    rs_use_decode u_dec (
        .opcode (id_opcode),
        .use1   (use1),
        .use2   (use2)
    );

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((use1 && (id_rs1 == ex_rd)) ||
                 (use2 && (id_rs2 == ex_rd)));

    assign miss = mem_req_valid && !mem_ready;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_stall = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = PIPELINE_CTRL_RUN;
            cnt_d        = '0;
        end else if (miss && state_q != PIPELINE_CTRL_MEM_WAIT) begin
            // Freeze everything; the flush counter is kept so an
            // interrupted flush resumes where it left off.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_d      = PIPELINE_CTRL_MEM_WAIT;
        end else if (state_q == PIPELINE_CTRL_MEM_WAIT && !mem_ready) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (state_q == PIPELINE_CTRL_FLUSH ||
                     (state_q == PIPELINE_CTRL_MEM_WAIT &&
                      cnt_q != '0)) begin
            // Flush cycle; a MEM_WAIT exit with a pending count is
            // itself a flush cycle so the total stays FLUSH_DEPTH.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (cnt_q <= CNT_ONE) begin
                state_d = PIPELINE_CTRL_RUN;
                cnt_d   = '0;
            end else begin
                state_d = PIPELINE_CTRL_FLUSH;
                cnt_d   = cnt_q - CNT_ONE;
            end
        end else begin
            // RUN, or MEM_WAIT exit with nothing pending.
            state_d = PIPELINE_CTRL_RUN;
            cnt_d   = '0;
            if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (FLUSH_DEPTH > 1) begin
                    state_d = PIPELINE_CTRL_FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end else if (lu) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PIPELINE_CTRL_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] perf_stall_q;
    logic [PERF_WIDTH-1:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_stall && !(&perf_stall_q))
                perf_stall_q <= perf_stall_q + 1'b1;
            if (if_id_flush && !(&perf_flush_q))
                perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: FLUSH_DEPTH=2 instance plus a
// FLUSH_DEPTH=1 instance sharing the same stimulus.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b110101;
    localparam logic [5:0] O_FLUSH = 6'b001010;
    localparam logic [5:0] O_LU    = 6'b110010;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, ex_redirect;
    logic       mem_req_valid, mem_ready;

    logic       pc_stall, if_id_stall, if_id_flush;
    logic       id_ex_stall, id_ex_bubble, ex_mem_stall;
    logic [1:0] state;
    logic       pc_stall1, if_id_stall1, if_id_flush1;
    logic       id_ex_stall1, id_ex_bubble1, ex_mem_stall1;
    logic [1:0] state1;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cycles;
    logic [31:0] perf_stall1, perf_flush1;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .id_opcode     (id_opcode),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_redirect   (ex_redirect),
        .mem_req_valid (mem_req_valid),
        .mem_ready     (mem_ready),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_stall  (ex_mem_stall),
        .state         (state)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cycles (perf_flush_cycles)
`endif
    );

    pipeline_ctrl #(.FLUSH_DEPTH(1)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .id_opcode     (id_opcode),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_redirect   (ex_redirect),
        .mem_req_valid (mem_req_valid),
        .mem_ready     (mem_ready),
        .pc_stall      (pc_stall1),
        .if_id_stall   (if_id_stall1),
        .if_id_flush   (if_id_flush1),
        .id_ex_stall   (id_ex_stall1),
        .id_ex_bubble  (id_ex_bubble1),
        .ex_mem_stall  (ex_mem_stall1),
        .state         (state1)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall1),
        .perf_flush_cycles (perf_flush1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check {state, outputs} of the depth-2 instance, then advance
    // to the next falling edge.
    task automatic vec(input string tag, input logic [1:0] st,
                       input logic [5:0] o);
        #1;
        chk(tag, {24'd0, state, pc_stall, if_id_stall, if_id_flush,
                  id_ex_stall, id_ex_bubble, ex_mem_stall},
            {24'd0, st, o});
        @(negedge clk);
    endtask

    task automatic vec1(input string tag, input logic [1:0] st,
                        input logic [5:0] o);
        chk(tag, {24'd0, state1, pc_stall1, if_id_stall1,
                  if_id_flush1, id_ex_stall1, id_ex_bubble1,
                  ex_mem_stall1},
            {24'd0, st, o});
    endtask

    task automatic id(input logic [6:0] opc, input logic [4:0] r1,
                      input logic [4:0] r2);
        id_opcode = opc;
        id_rs1    = r1;
        id_rs2    = r2;
    endtask

    initial begin
        rst = 1'b1;
        id(OPC_OP, 5'd1, 5'd2);
        ex_rd = 5'd0;
        ex_mem_read = 1'b0;
        ex_redirect = 1'b0;
        mem_req_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vec("reset", 2'd0, O_FLUSH);
        rst = 1'b0;
        vec("idle", 2'd0, O_NONE);

        // load x5 in EX, add x6,x5,x1 in ID
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id(OPC_OP, 5'd5, 5'd1);
        vec("lu_rs1", 2'd0, O_LU);
        ex_mem_read = 1'b0;
        vec("lu_done", 2'd0, O_NONE);
        ex_mem_read = 1'b1;
        id(OPC_OP, 5'd1, 5'd5);
        vec("lu_rs2", 2'd0, O_LU);
        ex_rd = 5'd0; id(OPC_OP, 5'd0, 5'd0);
        vec("lu_x0", 2'd0, O_NONE);
        ex_rd = 5'd5; id(OPC_LUI, 5'd5, 5'd5);
        vec("lu_lui", 2'd0, O_NONE);
        id(OPC_JAL, 5'd5, 5'd5);
        vec("lu_jal", 2'd0, O_NONE);
        id(OPC_JALR, 5'd5, 5'd0);
        vec("lu_jalr", 2'd0, O_LU);
        id(OPC_STORE, 5'd1, 5'd5);
        vec("lu_store", 2'd0, O_LU);
        id(OPC_OP_IMM, 5'd1, 5'd5);
        vec("lu_opimm_rs2", 2'd0, O_NONE);
        ex_mem_read = 1'b0;

        // redirect; load-use held during FLUSH is ignored
        ex_redirect = 1'b1;
        #1 vec1("redir1_c0", 2'd0, O_FLUSH);
        vec("redir_c0", 2'd0, O_FLUSH);
        ex_redirect = 1'b0;
        ex_mem_read = 1'b1; id(OPC_OP, 5'd5, 5'd1);
        #1 vec1("redir1_c1", 2'd0, O_LU);
        vec("redir_c1", 2'd1, O_FLUSH);
        ex_mem_read = 1'b0;
        vec("redir_c2", 2'd0, O_NONE);

        // 3-cycle memory wait
        mem_req_valid = 1'b1;
        vec("mw_c0", 2'd0, O_STALL);
        vec("mw_c1", 2'd2, O_STALL);
        vec("mw_c2", 2'd2, O_STALL);
        mem_ready = 1'b1;
        vec("mw_rel", 2'd2, O_NONE);
        mem_req_valid = 1'b0; mem_ready = 1'b0;
        vec("mw_after", 2'd0, O_NONE);

        // redirect together with a miss
        ex_redirect = 1'b1; mem_req_valid = 1'b1;
        vec("rm_c0", 2'd0, O_STALL);
        vec("rm_c1", 2'd2, O_STALL);
        mem_ready = 1'b1;
        vec("rm_rel", 2'd2, O_FLUSH);
        ex_redirect = 1'b0; mem_req_valid = 1'b0; mem_ready = 1'b0;
        vec("rm_fl", 2'd1, O_FLUSH);
        vec("rm_end", 2'd0, O_NONE);

        // miss during FLUSH resumes with remaining count
        ex_redirect = 1'b1;
        vec("fm_c0", 2'd0, O_FLUSH);
        ex_redirect = 1'b0; mem_req_valid = 1'b1;
        vec("fm_miss", 2'd1, O_STALL);
        vec("fm_wait", 2'd2, O_STALL);
        mem_ready = 1'b1;
        vec("fm_resume", 2'd2, O_FLUSH);
        mem_req_valid = 1'b0; mem_ready = 1'b0;
        vec("fm_end", 2'd0, O_NONE);

        // reset in FLUSH
        ex_redirect = 1'b1;
        vec("rf_c0", 2'd0, O_FLUSH);
        ex_redirect = 1'b0; rst = 1'b1;
        vec("rf_rst", 2'd1, O_FLUSH);
        rst = 1'b0;
        vec("rf_after", 2'd0, O_NONE);

        // reset in MEM_WAIT
        mem_req_valid = 1'b1;
        vec("rw_c0", 2'd0, O_STALL);
        rst = 1'b1;
        vec("rw_rst", 2'd2, O_FLUSH);
        rst = 1'b0; mem_req_valid = 1'b0;
        vec("rw_after", 2'd0, O_NONE);

`ifdef PIPELINE_CTRL_PERF_EN
        chk("perf_stall_rst", perf_stall_cycles, 32'd0);
        chk("perf_flush_rst", perf_flush_cycles, 32'd0);
        mem_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) vec("perf_miss", i == 0 ? 2'd0 : 2'd2, O_STALL);
        mem_ready = 1'b1;
        vec("perf_rel", 2'd2, O_NONE);
        mem_req_valid = 1'b0; mem_ready = 1'b0;
        chk("perf_stall5", perf_stall_cycles, 32'd5);
        chk("perf_flush0", perf_flush_cycles, 32'd0);
        ex_redirect = 1'b1;
        vec("perf_redir", 2'd0, O_FLUSH);
        ex_redirect = 1'b0;
        vec("perf_fl", 2'd1, O_FLUSH);
        chk("perf_flush2", perf_flush_cycles, 32'd2);
        chk("perf1_flush1", perf_flush1, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
